// File: rtl/add_seq_ctrl_pkg.sv
// add_seq_ctrl_pkg: shared state encoding and byte width for the add/sub sequencer
package add_seq_ctrl_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
  localparam int BYTE = 8;
endpackage

// File: rtl/add_seq_ctrl_if.sv
// add_seq_ctrl_if: operand request and result handshakes of the add/sub sequencer
interface add_seq_ctrl_if #(parameter int WIDTH = 32);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_a;
  logic [WIDTH-1:0] in_b;
  logic             in_sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_sum;
  logic             out_cout;
  logic             out_ovf;
  logic             out_zero;
  modport master (output in_valid, in_a, in_b, in_sub, out_ready,
                  input in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero);
  modport slave (input in_valid, in_a, in_b, in_sub, out_ready,
                 output in_ready, out_valid, out_sum, out_cout, out_ovf, out_zero);
endinterface

// File: rtl/add_seq_ctrl_add8_cin.sv
// add8_cin: 8-bit ripple adder slice with carry-in, exposing carry into bit 7 for overflow
module add8_cin (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       cin,
  output logic [7:0] s,
  output logic       c7,
  output logic       cout
);
  logic [8:0] c;
  assign c[0] = cin;
  for (genvar i = 0; i < 8; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign c7   = c[7];
  assign cout = c[8];
endmodule

// File: rtl/add_seq_ctrl.sv
// add_seq_ctrl: byte-serial add/subtract sequencer sharing one 8-bit slice, LSB byte first
module add_seq_ctrl
  import add_seq_ctrl_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic clk,
  input logic rst_n,
  add_seq_ctrl_if.slave bus
);
  localparam int NBYTES = WIDTH / BYTE;
  localparam int CW = NBYTES > 1 ? $clog2(NBYTES) : 1;
  state_t state, state_nx;
  logic [1:0] rst_sync;
  logic rst_i_n;
  logic [WIDTH-1:0] a_r, b_r, sum_r;
  logic [CW-1:0] cnt;
  logic carry, zacc, cout_r, ovf_r, zero_r;
  logic [BYTE-1:0] s;
  logic c7, cout;
  logic last;
  // async assert, deassert released through two flops
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) rst_sync <= 2'b00;
    else rst_sync <= {rst_sync[0], 1'b1};
  assign rst_i_n = rst_sync[1];
  assign last = cnt == CW'(NBYTES - 1);
  add8_cin u_add8 (
    .a(a_r[cnt*BYTE +: BYTE]), .b(b_r[cnt*BYTE +: BYTE]), .cin(carry),
    .s(s), .c7(c7), .cout(cout)
  );
  always_ff @(posedge clk or negedge rst_i_n)
    if (!rst_i_n) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE: state_nx = bus.in_valid ? RUN : IDLE;
      RUN: state_nx = last ? DONE : RUN;
      DONE: state_nx = bus.out_ready ? IDLE : DONE;
      default: state_nx = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_i_n)
    if (!rst_i_n) begin
      a_r <= '0;
      b_r <= '0;
      sum_r <= '0;
      cnt <= '0;
      carry <= 1'b0;
      zacc <= 1'b0;
      cout_r <= 1'b0;
      ovf_r <= 1'b0;
      zero_r <= 1'b0;
    end else if (state == IDLE && bus.in_valid) begin
      a_r <= bus.in_a;
      b_r <= bus.in_sub ? ~bus.in_b : bus.in_b;
      carry <= bus.in_sub;
      cnt <= '0;
      zacc <= 1'b1;
    end else if (state == RUN) begin
      sum_r[cnt*BYTE +: BYTE] <= s;
      carry <= cout;
      zacc <= zacc & (s == '0);
      cnt <= cnt + 1'b1;
      // flags are published only once the final byte has been added
      if (last) begin
        cout_r <= cout;
        ovf_r <= c7 ^ cout;
        zero_r <= zacc & (s == '0);
      end
    end
  assign bus.in_ready = state == IDLE;
  assign bus.out_valid = state == DONE;
  assign bus.out_sum = sum_r;
  assign bus.out_cout = cout_r;
  assign bus.out_ovf = ovf_r;
  assign bus.out_zero = zero_r;
endmodule

// File: tb/tb_add_seq_ctrl.sv
// tb_add_seq_ctrl: directed self-checking bench for the byte-serial add/sub sequencer
module tb_add_seq_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int tests = 0;
  int fails = 0;
  add_seq_ctrl_if #(.WIDTH(32)) bus ();
  add_seq_ctrl #(.WIDTH(32)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  always #5 clk = ~clk;
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                        input logic sub, input logic [31:0] es, input logic ec,
                        input logic eo, input logic ez);
    int n;
    bus.in_a = a;
    bus.in_b = b;
    bus.in_sub = sub;
    bus.in_valid = 1'b1;
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    step();
    bus.in_valid = 1'b0;
    n = 0;
    while (!bus.out_valid && n < 20) begin
      step();
      n++;
    end
    chk({tag, "_latency"}, n, 32'd4);
    chk({tag, "_sum"}, bus.out_sum, es);
    chk({tag, "_cout"}, 32'(bus.out_cout), 32'(ec));
    chk({tag, "_ovf"}, 32'(bus.out_ovf), 32'(eo));
    chk({tag, "_zero"}, 32'(bus.out_zero), 32'(ez));
    if (bus.out_ready) begin
      step();
      chk({tag, "_back_idle"}, 32'(bus.in_ready), 32'd1);
    end
  endtask
  initial begin
    bus.in_valid = 1'b0;
    bus.in_a = '0;
    bus.in_b = '0;
    bus.in_sub = 1'b0;
    bus.out_ready = 1'b1;
    #1;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_sum", bus.out_sum, 32'd0);
    chk("rst_flags", {29'd0, bus.out_cout, bus.out_ovf, bus.out_zero}, 32'd0);
    step();
    step();
    rst_n = 1'b1;
    repeat (3) step();
    run_op("add_ff_1", 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0);
    run_op("carry_chain", 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    run_op("sub_ovf", 32'h8000_0000, 32'h0000_0001, 1'b1, 32'h7FFF_FFFF, 1'b1, 1'b1, 1'b0);
    run_op("sub_borrow", 32'd3, 32'd5, 1'b1, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0);
    run_op("add_ovf", 32'h7FFF_FFFF, 32'h0000_0001, 1'b0, 32'h8000_0000, 1'b0, 1'b1, 1'b0);
    run_op("sub_equal", 32'h1234_5678, 32'h1234_5678, 1'b1, 32'h0000_0000, 1'b1, 1'b0, 1'b1);
    bus.out_ready = 1'b0;
    run_op("bp", 32'h1234_5678, 32'h1111_1111, 1'b0, 32'h2345_6789, 1'b0, 1'b0, 1'b0);
    bus.in_valid = 1'b1;
    bus.in_a = 32'hDEAD_BEEF;
    bus.in_b = 32'h0BAD_F00D;
    bus.in_sub = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("bp_hold_valid", 32'(bus.out_valid), 32'd1);
      chk("bp_hold_ready", 32'(bus.in_ready), 32'd0);
      chk("bp_hold_sum", bus.out_sum, 32'h2345_6789);
      chk("bp_hold_flags", {29'd0, bus.out_cout, bus.out_ovf, bus.out_zero}, 32'd0);
    end
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    step();
    chk("bp_release_idle", 32'(bus.in_ready), 32'd1);
    chk("bp_release_valid", 32'(bus.out_valid), 32'd0);
    chk("bp_release_sum", bus.out_sum, 32'h2345_6789);
    bus.in_a = 32'h0101_0101;
    bus.in_b = 32'h0202_0202;
    bus.in_sub = 1'b0;
    bus.in_valid = 1'b1;
    step();
    bus.in_valid = 1'b0;
    step();
    step();
    rst_n = 1'b0;
    #1;
    chk("midrun_in_ready", 32'(bus.in_ready), 32'd1);
    chk("midrun_out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrun_sum", bus.out_sum, 32'd0);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      chk("midrun_no_valid", 32'(bus.out_valid), 32'd0);
    end
    run_op("after_rst", 32'h0101_0101, 32'h0202_0202, 1'b0, 32'h0303_0303, 1'b0, 1'b0, 1'b0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/add_seq_ctrl.md
# add_seq_ctrl

Byte-serial add/subtract sequencer for the floating-point converter datapath. It shares one 8-bit ripple adder slice with an explicit carry-in. It accepts a WIDTH-bit operand pair over a valid/ready handshake and walks the slice LSB-byte-first, one byte per clock, holding the carry in a register between bytes. It returns the sum and status flags over a second valid/ready handshake. Converter stages that need wide mantissa or exponent arithmetic use it instead of instantiating a WIDTH-bit adder.

## Interface
- WIDTH, 32: operand width in bits; must be a multiple of 8, minimum 8.
- NBYTES, WIDTH/8: derived byte count; not overridden.

- clk  in  1  single clock; all state on rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  operand pair and op valid.
- in_ready  out  1  block can accept; high only in IDLE.
- in_a  in  WIDTH  operand A.
- in_b  in  WIDTH  operand B.
- in_sub  in  1  0 = A+B, 1 = A−B.
- out_valid  out  1  result valid; held until taken.
- out_ready  in  1  consumer takes result.
- out_sum  out  WIDTH  result, modulo 2^WIDTH.
- out_cout  out  1  carry out of MSB; for subtract, 1 = no borrow (A ≥ B unsigned).
- out_ovf  out  1  signed overflow = carry into MSB XOR carry out of MSB.
- out_zero  out  1  out_sum == 0.

## Operation
- States: IDLE, RUN, DONE.
- IDLE:
  - in_ready = 1.
  - On in_valid=1, capture in_a and in_sub into registers. Capture in_b if in_sub=0, ~in_b if in_sub=1.
  - Load the carry register with in_sub.
  - Clear the byte counter and the zero accumulator; go to RUN.
- RUN, byte index k = 0..NBYTES−1:
  - The slice adds A[8k+7:8k], B'[8k+7:8k] and the carry register.
  - Sum byte k is written into the result register.
  - The slice carry-out is written into the carry register.
  - The zero accumulator ANDs in (sum byte == 0).
  - At k = NBYTES−1, latch the carry into bit 7 of the slice (c7) for the overflow computation and go to DONE.
- DONE:
  - out_valid = 1; out_sum and flags are stable.
  - On out_ready=1, go to IDLE.
- Inputs in RUN and DONE are ignored; in_valid has no effect outside IDLE.
- out_ovf = c7 XOR final carry. out_cout = final carry. out_zero = zero accumulator.
- All arithmetic is unsigned modulo 2^WIDTH. The flags give signed interpretation.

## Timing
- Reset (async assert, sync-clean deassert inside the block):
  - state = IDLE, in_ready = 1, out_valid = 0.
  - out_sum = 0, out_cout = 0, out_ovf = 0, out_zero = 0.
  - Carry and counter cleared.
- Reset mid-RUN or mid-DONE aborts the operation and discards the result; no out_valid follows.
- Latency:
  - Acceptance edge at cycle 0. RUN occupies cycles 1..NBYTES.
  - out_valid rises after the edge ending cycle NBYTES. For WIDTH=32, out_valid is first seen in cycle 5.
- Throughput:
  - With out_ready tied high, DONE lasts 1 cycle and in_ready returns the following cycle.
  - Minimum issue interval is NBYTES+2 cycles.
- Output stability: out_sum and flags change only during RUN. While out_valid=1 and out_ready=0 they hold indefinitely.
- in_ready is combinational from state only. There is no combinational path from in_valid or out_ready to any output.

## Structure
- Shared package holds:
  - the state encoding constants IDLE=2'd0, RUN=2'd1, DONE=2'd2;
  - the BYTE=8 width constant.
- Sub-module add8_cin holds the 8-bit ripple adder slice built from full adders.
  - Ports: a[7:0], b[7:0], cin, s[7:0], c7 (carry into bit 7), cout.
  - It is purely combinational and instantiated once.
- The FSM, counter, operand registers and result register stay in add_seq_ctrl.

## Test plan
- Add, WIDTH=32: A=0x0000_00FF, B=0x0000_0001, sub=0. Required: out_sum=0x0000_0100, cout=0, ovf=0, zero=0, out_valid in cycle 5 after acceptance.
- Full carry chain: A=0xFFFF_FFFF, B=0x0000_0001, sub=0. Required: sum=0x0000_0000, cout=1, ovf=0, zero=1.
- Subtract with signed overflow: A=0x8000_0000, B=0x0000_0001, sub=1. Required: sum=0x7FFF_FFFF, cout=1, ovf=1, zero=0.
- Subtract with borrow: A=3, B=5, sub=1. Required: sum=0xFFFF_FFFE, cout=0, ovf=0.
- Backpressure and ignored input:
  - Hold out_ready=0 for 10 cycles in DONE while driving in_valid=1 with new operands.
  - Required: result and flags unchanged, in_ready=0, the new operands are not accepted.
  - Required after out_ready=1: IDLE one cycle later.
- Reset mid-RUN: assert rst_n=0 at RUN byte 2. Required: immediately in_ready=1, out_valid=0, out_sum=0. A fresh operation afterwards completes correctly.
